// File: rtl/pwm_led_array.sv
// Multi-channel PWM LED driver.
// One shared period counter (optionally prescaled) feeds CHANNELS comparators.
// Each channel has a double-buffered {mode, duty} register. Writes land in the
// shadow copy, and the active copy is updated only when the counter wraps.
// A channel is either static (its duty is the shadow value) or breathing
// (its duty ramps 0..max..0 by one step per period and holds for one period
// at each end).
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active low
//   duty_in    duty value to write
//   ch_sel     channel addressed by a write; values >= CHANNELS are ignored
//   mode_in    mode to write (0 static, 1 breathe)
//   load       one-cycle write strobe into shadow[ch_sel]
//   leds       registered PWM outputs, one cycle behind the counter
//   period_tk  one-cycle pulse that starts on the edge where the counter wraps
module pwm_led_array #(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned WIDTH    = 6,
  parameter int unsigned PRESCALE = 1,
  localparam int unsigned SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    duty_in,
  input  logic [SEL_W-1:0]    ch_sel,
  input  logic                mode_in,
  input  logic                load,
  output logic [CHANNELS-1:0] leds,
  output logic                period_tk
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] DUTY_MAX = '1;

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    shadow_duty_q [CHANNELS];
  logic [WIDTH-1:0]    shadow_duty_d [CHANNELS];
  logic [WIDTH-1:0]    active_duty_q [CHANNELS];
  logic [WIDTH-1:0]    active_duty_d [CHANNELS];
  logic [CHANNELS-1:0] shadow_mode_q, shadow_mode_d;
  logic [CHANNELS-1:0] active_mode_q, active_mode_d;
  logic [CHANNELS-1:0] dir_down_q, dir_down_d;
  logic [CHANNELS-1:0] leds_d;
  logic                period_tk_d;

  logic step_c;
  logic wrap_c;

  // Counter advance strobe and end-of-period detect.
  assign step_c = (pre_q == PRE_LAST);
  assign wrap_c = step_c && (cnt_q == DUTY_MAX);

  // Next-state and output logic.
  always_comb begin
    pre_d         = step_c ? '0 : pre_q + PRE_W'(1);
    cnt_d         = step_c ? cnt_q + WIDTH'(1) : cnt_q;
    shadow_mode_d = shadow_mode_q;
    active_mode_d = active_mode_q;
    dir_down_d    = dir_down_q;
    period_tk_d   = wrap_c;
    leds_d        = '0;

    for (int unsigned i = 0; i < CHANNELS; i++) begin
      shadow_duty_d[i] = shadow_duty_q[i];
      active_duty_d[i] = active_duty_q[i];

      // Out-of-range ch_sel never matches any channel index.
      if (load && (ch_sel == SEL_W'(i))) begin
        shadow_duty_d[i] = duty_in;
        shadow_mode_d[i] = mode_in;
      end

      // Commit uses the pre-edge shadow, so a load on the wrap edge waits a period.
      if (wrap_c) begin
        active_mode_d[i] = shadow_mode_q[i];
        if (!shadow_mode_q[i]) begin
          active_duty_d[i] = shadow_duty_q[i];
          dir_down_d[i]    = 1'b0;
        end else if (!active_mode_q[i] || !dir_down_q[i]) begin
          // Ramping up (a fresh switch from static always starts upward).
          if (active_duty_q[i] == DUTY_MAX) begin
            dir_down_d[i] = 1'b1;
          end else begin
            active_duty_d[i] = active_duty_q[i] + WIDTH'(1);
            dir_down_d[i]    = 1'b0;
          end
        end else begin
          if (active_duty_q[i] == '0) begin
            dir_down_d[i] = 1'b0;
          end else begin
            active_duty_d[i] = active_duty_q[i] - WIDTH'(1);
          end
        end
      end

      // All-ones duty is fully on; otherwise high while cnt < duty.
      leds_d[i] = (active_duty_q[i] == DUTY_MAX) || (cnt_q < active_duty_q[i]);
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_q         <= '0;
      cnt_q         <= '0;
      shadow_mode_q <= '0;
      active_mode_q <= '0;
      dir_down_q    <= '0;
      leds          <= '0;
      period_tk     <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        shadow_duty_q[i] <= '0;
        active_duty_q[i] <= '0;
      end
    end else begin
      pre_q         <= pre_d;
      cnt_q         <= cnt_d;
      shadow_mode_q <= shadow_mode_d;
      active_mode_q <= active_mode_d;
      dir_down_q    <= dir_down_d;
      leds          <= leds_d;
      period_tk     <= period_tk_d;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        shadow_duty_q[i] <= shadow_duty_d[i];
        active_duty_q[i] <= active_duty_d[i];
      end
    end
  end

endmodule
